// File: rtl/projectile_pool_if.sv
// Control and query bundle for projectile_pool.
// The master side drives fire/tick/kill/query inputs; the slave side returns slot state and pixel hits.
interface projectile_pool_if #(
  parameter int NUM_BULLETS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7
);
  logic                       tick;
  logic                       fire_req;
  logic [1:0]                 fire_dir;
  logic [X_W-1:0]             ship_x;
  logic [Y_W-1:0]             ship_y;
  logic [NUM_BULLETS-1:0]     kill;
  logic [X_W-1:0]             px;
  logic [Y_W-1:0]             py;
  logic                       fire_ack;
  logic                       full;
  logic [NUM_BULLETS-1:0]     active;
  logic [NUM_BULLETS*X_W-1:0] bx_flat;
  logic [NUM_BULLETS*Y_W-1:0] by_flat;
  logic                       pix_hit;
  logic [3:0]                 pix_slot;

  modport master (
    output tick, fire_req, fire_dir, ship_x, ship_y, kill, px, py,
    input  fire_ack, full, active, bx_flat, by_flat, pix_hit, pix_slot
  );

  modport slave (
    input  tick, fire_req, fire_dir, ship_x, ship_y, kill, px, py,
    output fire_ack, full, active, bx_flat, by_flat, pix_hit, pix_slot
  );
endinterface

// File: rtl/projectile_pool.sv
// Multi-bullet pool: spawn at the ship on fire, move on game tick, retire off-screen, 1-cycle pixel query.
// Optional spawn cooldown is enabled by defining PROJ_COOLDOWN_EN.
module projectile_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int STEP        = 2,
  parameter int COOLDOWN    = 8
) (
  input logic              clock,
  input logic              resetn,
  projectile_pool_if.slave bus
);
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef struct packed {
    logic           retire;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } move_t;

  localparam logic [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic [Y_W:0] STEP_Y = (Y_W+1)'(STEP);
  localparam logic [X_W:0] X_LIM  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(SCREEN_H);

  logic [NUM_BULLETS-1:0] active;
  logic [X_W-1:0]         bx  [NUM_BULLETS];
  logic [Y_W-1:0]         by  [NUM_BULLETS];
  dir_e                   dir [NUM_BULLETS];
  logic                   fire_ack;
  logic                   pix_hit;
  logic [3:0]             pix_slot;
  logic                   armed;

  move_t                  mv  [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] spawn_mask;
  logic                   on_screen;
  logic                   cool_ok;
  logic                   spawn;
  logic                   hit_any;
  logic [3:0]             hit_idx;

  // One extra bit on each coordinate so the screen-edge test never wraps.
  function automatic move_t step_slot(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input dir_e d);
    logic [X_W:0] xe;
    logic [Y_W:0] ye;
    move_t        m;
    // NOTE: blocking assignments are right for function locals; each line sees the previous result.
    xe       = {1'b0, x};
    ye       = {1'b0, y};
    m.retire = 1'b0;
    case (d)
      DIR_UP:    begin m.retire = ye < STEP_Y; ye = ye - STEP_Y; end
      DIR_RIGHT: begin xe = xe + STEP_X; m.retire = xe >= X_LIM; end
      DIR_DOWN:  begin ye = ye + STEP_Y; m.retire = ye >= Y_LIM; end
      default:   begin m.retire = xe < STEP_X; xe = xe - STEP_X; end
    endcase
    m.x = xe[X_W-1:0];
    m.y = ye[Y_W-1:0];
    return m;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) mv[i] = step_slot(bx[i], by[i], dir[i]);
  end

  // Lowest clear bit of the registered live mask; slots freed this cycle are still counted as busy.
  assign spawn_mask = ~active & (active + NUM_BULLETS'(1));
  assign on_screen  = ({1'b0, bus.ship_x} < X_LIM) && ({1'b0, bus.ship_y} < Y_LIM);
  assign spawn      = bus.fire_req && armed && !(&active) && on_screen && cool_ok;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (active[i] && bx[i] == bus.px && by[i] == bus.py) begin
        hit_any = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

`ifdef PROJ_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN + 1);
  logic [CW-1:0] cool_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                              cool_cnt <= '0;
    else if (spawn)                           cool_cnt <= CW'(COOLDOWN);
    else if (bus.tick && cool_cnt != '0)      cool_cnt <= cool_cnt - CW'(1);
  end

  assign cool_ok = (cool_cnt == '0);
`else
  assign cool_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active   <= '0;
      fire_ack <= 1'b0;
      pix_hit  <= 1'b0;
      pix_slot <= '0;
      armed    <= 1'b1;
      // NOTE: slot state lives in flops, not RAM, so clearing it on reset is cheap and required.
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx[i]  <= '0;
        by[i]  <= '0;
        dir[i] <= DIR_UP;
      end
    end else begin
      fire_ack <= spawn;
      pix_hit  <= hit_any;
      pix_slot <= hit_idx;
      // Held fire spawns once per tick window: re-arm on a low request or a tick.
      if (spawn)                            armed <= 1'b0;
      else if (!bus.fire_req || bus.tick)   armed <= 1'b1;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (spawn && spawn_mask[i]) begin
          active[i] <= 1'b1;
          bx[i]     <= bus.ship_x;
          by[i]     <= bus.ship_y;
          dir[i]    <= dir_e'(bus.fire_dir);
        end else if (bus.kill[i]) begin
          active[i] <= 1'b0;
        end else if (bus.tick && active[i]) begin
          if (mv[i].retire) begin
            active[i] <= 1'b0;
          end else begin
            bx[i] <= mv[i].x;
            by[i] <= mv[i].y;
          end
        end
      end
    end
  end

  assign bus.active   = active;
  assign bus.full     = &active;
  assign bus.fire_ack = fire_ack;
  assign bus.pix_hit  = pix_hit;
  assign bus.pix_slot = pix_slot;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_flat
    assign bus.bx_flat[g*X_W +: X_W] = bx[g];
    assign bus.by_flat[g*Y_W +: Y_W] = by[g];
  end
endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool: directed vector table, corner-case sequences,
// and randomized traffic against a slot-list reference model.
module tb_projectile_pool;
  localparam int NB   = 4;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int SW   = 160;
  localparam int SH   = 120;
  localparam int STEP = 2;
  localparam int COOL = 8;
`ifdef PROJ_COOLDOWN_EN
  localparam int GAP  = COOL + 1;
`else
  localparam int GAP  = 1;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b1;

  projectile_pool_if #(.NUM_BULLETS(NB), .X_W(XW), .Y_W(YW)) bus ();

  projectile_pool #(
    .NUM_BULLETS(NB), .X_W(XW), .Y_W(YW), .SCREEN_W(SW), .SCREEN_H(SH),
    .STEP(STEP), .COOLDOWN(COOL)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a list of slots held as plain integers, advanced once per clock edge.
  int m_live [NB];
  int m_x    [NB];
  int m_y    [NB];
  int m_d    [NB];
  int m_ack, m_armed, m_cool, m_hit, m_slot;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_live[i] = 0; m_x[i] = 0; m_y[i] = 0; m_d[i] = 0;
    end
    m_ack = 0; m_armed = 1; m_cool = 0; m_hit = 0; m_slot = 0;
  endfunction

  function automatic void model_clock();
    int  free_s = -1;
    int  hit = 0, slot = 0, nx, ny;
    bit  ok;
    for (int i = NB - 1; i >= 0; i--)
      if (m_live[i] != 0 && m_x[i] == int'(bus.px) && m_y[i] == int'(bus.py)) begin
        hit = 1; slot = i;
      end
    for (int i = NB - 1; i >= 0; i--) if (m_live[i] == 0) free_s = i;
    ok = bus.fire_req && m_armed != 0 && free_s >= 0 && int'(bus.ship_x) < SW && int'(bus.ship_y) < SH;
`ifdef PROJ_COOLDOWN_EN
    ok = ok && m_cool == 0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (m_live[i] != 0) begin
        if (bus.kill[i]) m_live[i] = 0;
        else if (bus.tick) begin
          nx = m_x[i]; ny = m_y[i];
          case (m_d[i])
            0:       ny = ny - STEP;
            1:       nx = nx + STEP;
            2:       ny = ny + STEP;
            default: nx = nx - STEP;
          endcase
          if (nx < 0 || nx >= SW || ny < 0 || ny >= SH) m_live[i] = 0;
          else begin m_x[i] = nx; m_y[i] = ny; end
        end
      end
    end
    if (ok) begin
      m_live[free_s] = 1;
      m_x[free_s]    = int'(bus.ship_x);
      m_y[free_s]    = int'(bus.ship_y);
      m_d[free_s]    = int'(bus.fire_dir);
    end
    if (ok) m_armed = 0;
    else if (!bus.fire_req || bus.tick) m_armed = 1;
`ifdef PROJ_COOLDOWN_EN
    if (ok) m_cool = COOL;
    else if (bus.tick && m_cool > 0) m_cool = m_cool - 1;
`endif
    m_ack = ok ? 1 : 0; m_hit = hit; m_slot = slot;
  endfunction

  task automatic compare_model();
    logic [NB-1:0]    ea;
    logic [NB*XW-1:0] ex;
    logic [NB*YW-1:0] ey;
    for (int i = 0; i < NB; i++) begin
      ea[i]            = (m_live[i] != 0);
      ex[i*XW +: XW]   = XW'(m_x[i]);
      ey[i*YW +: YW]   = YW'(m_y[i]);
    end
    check("model_ack",      bus.fire_ack, m_ack);
    check("model_active",   bus.active,   ea);
    check("model_full",     bus.full,     &ea);
    check("model_pix_hit",  bus.pix_hit,  m_hit);
    check("model_pix_slot", bus.pix_slot, m_slot);
    check("model_bx",       bus.bx_flat,  ex);
    check("model_by",       bus.by_flat,  ey);
  endtask

  function automatic int bxs(input int i);
    return int'(bus.bx_flat[i*XW +: XW]);
  endfunction

  function automatic int bys(input int i);
    return int'(bus.by_flat[i*YW +: YW]);
  endfunction

  // One clock cycle: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input bit t, input bit f, input int d, input int sx, input int sy,
                      input int k, input int qx, input int qy);
    bus.tick = t; bus.fire_req = f; bus.fire_dir = 2'(d);
    bus.ship_x = XW'(sx); bus.ship_y = YW'(sy); bus.kill = NB'(k);
    bus.px = XW'(qx); bus.py = YW'(qy);
    @(posedge clock);
    model_clock();
    @(negedge clock);
    compare_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst_active",   bus.active,   0);
    check("rst_pix_hit",  bus.pix_hit,  0);
    check("rst_fire_ack", bus.fire_ack, 0);
    check("rst_full",     bus.full,     0);
    model_reset();
    bus.tick = 0; bus.fire_req = 0; bus.fire_dir = 0; bus.ship_x = 0; bus.ship_y = 0;
    bus.kill = 0; bus.px = 0; bus.py = 0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  typedef struct {
    bit tick, fire;
    int dir, sx, sy, kill, qx, qy;
    bit e_ack;
    int e_active;
    bit e_hit;
    int e_slot, e_x0, e_y0;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Spawn, three ticks of upward motion, pixel query latency, kill and kill-on-dead.
    tbl[0] = '{0, 0, 0,  0,  0, 0,  0,  0, 0, 0, 0, 0,  0,  0};
    tbl[1] = '{0, 1, 0, 80, 60, 0,  0,  0, 1, 1, 0, 0, 80, 60};
    tbl[2] = '{0, 0, 0,  0,  0, 0, 80, 60, 0, 1, 1, 0, 80, 60};
    tbl[3] = '{1, 0, 0,  0,  0, 0, 80, 60, 0, 1, 1, 0, 80, 58};
    tbl[4] = '{1, 0, 0,  0,  0, 0, 80, 60, 0, 1, 0, 0, 80, 56};
    tbl[5] = '{1, 0, 0,  0,  0, 0, 80, 56, 0, 1, 1, 0, 80, 54};
    tbl[6] = '{0, 0, 0,  0,  0, 1, 80, 54, 0, 0, 1, 0, 80, 54};
    tbl[7] = '{0, 0, 0,  0,  0, 1, 80, 54, 0, 0, 0, 0, 80, 54};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].tick, tbl[i].fire, tbl[i].dir, tbl[i].sx, tbl[i].sy, tbl[i].kill, tbl[i].qx, tbl[i].qy);
      check($sformatf("tbl%0d_ack", i),    bus.fire_ack, tbl[i].e_ack);
      check($sformatf("tbl%0d_active", i), bus.active,   tbl[i].e_active);
      check($sformatf("tbl%0d_hit", i),    bus.pix_hit,  tbl[i].e_hit);
      check($sformatf("tbl%0d_slot", i),   bus.pix_slot, tbl[i].e_slot);
      check($sformatf("tbl%0d_x0", i),     bxs(0),       tbl[i].e_x0);
      check($sformatf("tbl%0d_y0", i),     bys(0),       tbl[i].e_y0);
    end

    // Retire at the right edge without wrapping, then at the top edge after landing on y=0.
    do_reset();
    step(0, 1, 1, 158, 10, 0, 0, 0);
    check("ret_spawn_ack", bus.fire_ack, 1);
    check("ret_spawn_x",   bxs(0),       158);
    ticks(1);
    check("ret_right_active", bus.active, 0);
    check("ret_right_nowrap", bxs(0),     158);
    ticks(GAP - 1);
    step(0, 1, 0, 5, 2, 0, 0, 0);
    check("ret_up_ack", bus.fire_ack, 1);
    ticks(1);
    check("ret_up_live", bus.active, 1);
    check("ret_up_y0",   bys(0),     0);
    ticks(1);
    check("ret_up_gone", bus.active, 0);

    // Fill all slots, reject when full, kill slot2 and refill it.
    do_reset();
    for (int k = 0; k < NB; k++) begin
      step(0, 1, 2, 20, 10, 0, 0, 0);
      check($sformatf("full_spawn%0d_ack", k), bus.fire_ack, 1);
      check($sformatf("full_spawn%0d_act", k), bus.active,   (1 << (k + 1)) - 1);
      ticks(GAP);
    end
    check("full_flag", bus.full, 1);
    step(0, 1, 2, 20, 10, 0, 0, 0);
    check("full_reject_ack", bus.fire_ack, 0);
    check("full_reject_act", bus.active,   4'b1111);
    step(0, 0, 0, 0, 0, 4'b0100, 0, 0);
    check("full_kill_act",  bus.active, 4'b1011);
    check("full_kill_full", bus.full,   0);
    step(0, 1, 2, 30, 40, 0, 0, 0);
    check("full_refill_ack", bus.fire_ack, 1);
    check("full_refill_act", bus.active,   4'b1111);
    check("full_refill_x2",  bxs(2),       30);
    check("full_refill_y2",  bys(2),       40);

    // Tick, fire and kill of slot0 in one cycle: slot0 not reused, newcomer in slot2 unmoved.
    do_reset();
    step(0, 1, 0, 50, 50, 0, 0, 0);
    ticks(GAP);
    step(0, 1, 0, 60, 50, 0, 0, 0);
    check("sim_pre_act", bus.active, 4'b0011);
    ticks(GAP);
    step(1, 1, 1, 70, 70, 4'b0001, 0, 0);
    check("sim_ack", bus.fire_ack, 1);
    check("sim_act", bus.active,   4'b0110);
    check("sim_x2",  bxs(2),       70);
    check("sim_y2",  bys(2),       70);
    check("sim_y1",  bys(1),       50 - STEP * (GAP + 1));
    ticks(GAP);
    step(0, 1, 3, 90, 90, 0, 0, 0);
    check("sim_reuse_act", bus.active, 4'b0111);
    check("sim_reuse_x0",  bxs(0),     90);

    // Off-screen spawns rejected, pixel query on slot1, then reset with three live slots.
    do_reset();
    step(0, 1, 0, SW, 5, 0, 0, 0);
    check("off_x_ack", bus.fire_ack, 0);
    step(0, 1, 0, 5, SH, 0, 0, 0);
    check("off_y_ack", bus.fire_ack, 0);
    check("off_act",   bus.active,   0);
    step(0, 1, 1, 10, 100, 0, 0, 0);
    check("q_spawn0_ack", bus.fire_ack, 1);
    ticks(GAP);
    step(0, 1, 0, 40, 30, 0, 0, 0);
    check("q_spawn1_act", bus.active, 4'b0011);
    step(0, 0, 0, 0, 0, 0, 40, 30);
    check("q_hit",  bus.pix_hit,  1);
    check("q_slot", bus.pix_slot, 1);
    ticks(GAP);
    step(0, 1, 3, 100, 100, 0, 0, 0);
    check("q_three_live", bus.active, 4'b0111);
    step(0, 0, 0, 0, 0, 0, 40, 30 - STEP * GAP);
    check("q_hit_moved",  bus.pix_hit,  1);
    check("q_slot_moved", bus.pix_slot, 1);
    do_reset();

    // Held fire: one spawn per tick window.
    step(0, 1, 0, 60, 60, 0, 0, 0);
    check("arm_first_ack", bus.fire_ack, 1);
    step(0, 1, 0, 60, 60, 0, 0, 0);
    check("arm_held_ack", bus.fire_ack, 0);
    step(1, 1, 0, 60, 60, 0, 0, 0);
    check("arm_tick_ack", bus.fire_ack, 0);
    step(0, 1, 0, 60, 60, 0, 0, 0);
`ifdef PROJ_COOLDOWN_EN
    check("arm_cooldown_ack", bus.fire_ack, 0);
    repeat (COOL - 1) step(1, 1, 0, 60, 60, 0, 0, 0);
    step(0, 1, 0, 60, 60, 0, 0, 0);
    check("arm_cooldown_done_ack", bus.fire_ack, 1);
`else
    check("arm_rearmed_ack", bus.fire_ack, 1);
`endif

    // Randomized traffic against the model.
    do_reset();
    repeat (600) begin
      int k = 0;
      int j = $urandom_range(0, NB - 1);
      int qx, qy;
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 7) == 0) k |= (1 << b);
      if ($urandom_range(0, 1) == 0) begin
        qx = m_x[j]; qy = m_y[j];
      end else begin
        qx = $urandom_range(0, SW - 1); qy = $urandom_range(0, SH - 1);
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 170), $urandom_range(0, 127), k, qx, qy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
